// File: rtl/lcg_stim_pkg.sv
// Shared constants, state/mode encodings and the LCG step for the stimulus generator.
package lcg_stim_pkg;

  localparam logic [31:0] LCG_A        = 32'h41C64E6D;
  localparam logic [31:0] LCG_C        = 32'h3039;
  localparam logic [31:0] DEFAULT_POLY = 32'h04C11DB7;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    MODE_LCG  = 2'd0,
    MODE_HOLD = 2'd1,
    MODE_WALK = 2'd2
  } mode_e;

  function automatic logic [31:0] lcg_next(input logic [31:0] s);
    return s * LCG_A + LCG_C;
  endfunction

endpackage

// File: rtl/lcg_stim_gen_sig_misr.sv
// Response compactor: XOR-folds the DUT output into SIG_W bits and clocks it into a MISR.
module sig_misr #(
  parameter int unsigned OUT_W = 159,
  parameter int unsigned SIG_W = 32,
  parameter logic [31:0] POLY  = 32'h04C11DB7
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic [OUT_W-1:0] data,
  output logic [SIG_W-1:0] sig_o
);
  localparam int unsigned NCH   = (OUT_W + SIG_W - 1) / SIG_W;
  localparam int unsigned PAD_W = NCH * SIG_W;
  localparam logic [SIG_W-1:0] P = POLY[SIG_W-1:0];

  logic [PAD_W-1:0] w_pad;
  logic [SIG_W-1:0] w_fold;

  always_comb begin
    w_pad  = PAD_W'(data);
    w_fold = '0;
    for (int i = 0; i < NCH; i++) begin
      w_fold = w_fold ^ w_pad[i*SIG_W +: SIG_W];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig_o <= '0;
    end else if (clr) begin
      sig_o <= '0;
    end else if (en) begin
      sig_o <= {sig_o[SIG_W-2:0], 1'b0} ^ (sig_o[SIG_W-1] ? P : '0) ^ w_fold;
    end
  end

endmodule

// File: rtl/lcg_stim_gen.sv
// LCG-driven DUT stimulus generator: fills a wide vector word-by-word, publishes it, and signs the responses.
module lcg_stim_gen
  import lcg_stim_pkg::*;
#(
  parameter int unsigned IN_W  = 138,
  parameter int unsigned OUT_W = 159,
  parameter logic [31:0] SEED  = 32'd784456416,
  parameter int unsigned CNT_W = 16,
  parameter int unsigned SIG_W = 32,
  parameter logic [31:0] POLY  = DEFAULT_POLY
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             seed_load_i,
  input  logic [31:0]      seed_i,
  input  logic             start_i,
  input  logic [CNT_W-1:0] num_vec_i,
  input  logic [1:0]       mode_i,
  output logic [IN_W-1:0]  in_flat_o,
  output logic             vec_valid_o,
  input  logic [OUT_W-1:0] out_flat_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [CNT_W-1:0] vec_cnt_o,
  output logic [SIG_W-1:0] sig_o
);
  localparam int unsigned NWORDS = (IN_W + 31) / 32;
  localparam int unsigned IDX_W  = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam int unsigned POS_W  = (IN_W > 1) ? $clog2(IN_W) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NWORDS - 1);
  localparam logic [POS_W-1:0] LAST_POS = POS_W'(IN_W - 1);

  state_e                   r_state;
  mode_e                    r_mode;
  logic [31:0]              r_rng;
  logic [NWORDS-1:0][31:0]  r_stage;
  logic [IDX_W-1:0]         r_idx;
  logic [POS_W-1:0]         r_pos;
  logic [CNT_W-1:0]         r_num_vec;

  logic [NWORDS-1:0][31:0]  w_stage_nxt;
  logic [31:0]              w_lcg;
  logic [IN_W-1:0]          w_walk;
  logic                     w_idle_done;
  logic                     w_accept;
  logic                     w_adv;
  logic                     w_wrap;
  logic                     w_pub;
  logic                     w_last;
  logic                     w_sig_en;

  // HOLD only draws from the LCG until its first vector is published.
  always_comb begin
    w_lcg       = lcg_next(r_rng);
    w_walk      = IN_W'(1) << r_pos;
    w_idle_done = (r_state == IDLE) || (r_state == DONE);
    w_accept    = start_i && w_idle_done;
    w_wrap      = (r_idx == LAST_IDX);
    w_adv       = (r_state == FILL) &&
                  ((r_mode == MODE_LCG) || ((r_mode == MODE_HOLD) && (vec_cnt_o == '0)));
    w_pub       = (r_state == FILL) && w_wrap;
    w_last      = w_pub && (CNT_W'(vec_cnt_o + 1'b1) == r_num_vec);
    w_sig_en    = (w_pub && (vec_cnt_o != '0)) || ((r_state == DRAIN) && w_wrap);
    w_stage_nxt = r_stage;
    if (w_adv) w_stage_nxt[r_idx] = w_lcg;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_mode      <= MODE_LCG;
      r_rng       <= SEED;
      r_stage     <= '0;
      r_idx       <= '0;
      r_pos       <= '0;
      r_num_vec   <= '0;
      in_flat_o   <= '0;
      vec_valid_o <= 1'b0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      vec_cnt_o   <= '0;
    end else begin
      vec_valid_o <= 1'b0;
      if (seed_load_i && w_idle_done) r_rng <= seed_i;
      case (r_state)
        IDLE, DONE: begin
          if (start_i) begin
            vec_cnt_o <= '0;
            r_idx     <= '0;
            r_pos     <= '0;
            r_num_vec <= num_vec_i;
            r_mode    <= (mode_i == 2'd1) ? MODE_HOLD :
                         (mode_i == 2'd2) ? MODE_WALK : MODE_LCG;
            if (num_vec_i == '0) begin
              r_state <= DONE;
              busy_o  <= 1'b0;
              done_o  <= 1'b1;
            end else begin
              r_state <= FILL;
              busy_o  <= 1'b1;
              done_o  <= 1'b0;
            end
          end
        end
        FILL: begin
          if (w_adv) begin
            r_rng   <= w_lcg;
            r_stage <= w_stage_nxt;
          end
          if (w_wrap) begin
            r_idx       <= '0;
            in_flat_o   <= (r_mode == MODE_WALK) ? w_walk : IN_W'(w_stage_nxt);
            vec_valid_o <= 1'b1;
            vec_cnt_o   <= vec_cnt_o + 1'b1;
            if (r_mode == MODE_WALK) r_pos <= (r_pos == LAST_POS) ? '0 : r_pos + 1'b1;
            if (w_last) r_state <= DRAIN;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        DRAIN: begin
          // Final vector is held a full period so its response is settled before the last sample.
          if (w_wrap) begin
            r_idx   <= '0;
            r_state <= DONE;
            busy_o  <= 1'b0;
            done_o  <= 1'b1;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  sig_misr #(
    .OUT_W (OUT_W),
    .SIG_W (SIG_W),
    .POLY  (POLY)
  ) u_sig_misr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (w_accept),
    .en    (w_sig_en),
    .data  (out_flat_i),
    .sig_o (sig_o)
  );

endmodule

// File: tb/tb_lcg_stim_gen.sv
// Randomized self-checking bench for lcg_stim_gen against a vector-list / signature reference model.
module tb_lcg_stim_gen;
  localparam int unsigned IN_W   = 138;
  localparam int unsigned OUT_W  = 159;
  localparam int unsigned SIG_W  = 32;
  localparam int unsigned CNT_W  = 16;
  localparam int unsigned NWORDS = (IN_W + 31) / 32;
  localparam logic [31:0] SEED   = 32'd784456416;
  localparam logic [31:0] POLY   = 32'h04C11DB7;

  logic             clk;
  logic             rst_n;
  logic             seed_load_i;
  logic [31:0]      seed_i;
  logic             start_i;
  logic [CNT_W-1:0] num_vec_i;
  logic [1:0]       mode_i;
  logic [IN_W-1:0]  in_flat_o;
  logic             vec_valid_o;
  logic [OUT_W-1:0] out_flat;
  logic             busy_o;
  logic             done_o;
  logic [CNT_W-1:0] vec_cnt_o;
  logic [SIG_W-1:0] sig_o;

  int n_tests = 0;
  int n_fail  = 0;

  logic             resp_mode;
  logic [OUT_W-1:0] salt;
  logic [31:0]      m_rng;
  logic [IN_W-1:0]  exp_q[$];
  logic [SIG_W-1:0] m_sig;

  lcg_stim_gen u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .seed_load_i (seed_load_i),
    .seed_i      (seed_i),
    .start_i     (start_i),
    .num_vec_i   (num_vec_i),
    .mode_i      (mode_i),
    .in_flat_o   (in_flat_o),
    .vec_valid_o (vec_valid_o),
    .out_flat_i  (out_flat),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .vec_cnt_o   (vec_cnt_o),
    .sig_o       (sig_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stand-in DUT: either a constant 1 or a salted function of the applied vector.
  function automatic logic [OUT_W-1:0] f_resp(input logic [IN_W-1:0] v, input logic rm,
                                              input logic [OUT_W-1:0] s);
    if (rm) return {v, v[20:0]} ^ s;
    return OUT_W'(1);
  endfunction

  assign out_flat = f_resp(in_flat_o, resp_mode, salt);

  task automatic check(input string tag, input logic [191:0] got, input logic [191:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [SIG_W-1:0] m_fold(input logic [OUT_W-1:0] r);
    logic [SIG_W-1:0] f;
    f = '0;
    for (int b = 0; b < OUT_W; b++) f[b % SIG_W] = f[b % SIG_W] ^ r[b];
    return f;
  endfunction

  function automatic logic [SIG_W-1:0] m_step(input logic [SIG_W-1:0] s, input logic [SIG_W-1:0] f);
    return (s << 1) ^ (s[SIG_W-1] ? POLY : 32'd0) ^ f;
  endfunction

  task automatic m_gen(output logic [IN_W-1:0] v);
    logic [NWORDS*32-1:0] acc;
    for (int w = 0; w < NWORDS; w++) begin
      m_rng = m_rng * 32'h41C64E6D + 32'h3039;
      acc[w*32 +: 32] = m_rng;
    end
    v = acc[IN_W-1:0];
  endtask

  task automatic run(input logic sl, input logic [31:0] sd, input logic [1:0] md, input int nv);
    logic [IN_W-1:0] v;
    logic [IN_W-1:0] prev;
    int cyc;
    int k;
    int bad;
    int budget;
    if (sl) m_rng = sd;
    exp_q.delete();
    m_sig = '0;
    for (int i = 0; i < nv; i++) begin
      if (md == 2'd2) v = IN_W'(1) << (i % IN_W);
      else if (md == 2'd1 && i > 0) v = exp_q[0];
      else m_gen(v);
      exp_q.push_back(v);
      m_sig = m_step(m_sig, m_fold(f_resp(v, resp_mode, salt)));
    end
    seed_load_i = sl;
    seed_i      = sd;
    mode_i      = md;
    num_vec_i   = CNT_W'(nv);
    start_i     = 1'b1;
    @(posedge clk); #1;
    seed_load_i = 1'b0;
    start_i     = 1'b0;
    cyc    = 0;
    k      = 0;
    bad    = 0;
    budget = NWORDS * (nv + 2) + 8;
    prev   = in_flat_o;
    while (!done_o && cyc < budget) begin
      start_i   = busy_o && ($urandom_range(0, 7) == 0);
      mode_i    = 2'($urandom);
      num_vec_i = CNT_W'($urandom);
      @(posedge clk); #1;
      cyc++;
      if (vec_valid_o) begin
        if (k < nv) begin
          check("vec", in_flat_o, exp_q[k]);
          check("pub_cyc", cyc, NWORDS * (k + 1));
        end
        k++;
      end else if (in_flat_o !== prev) begin
        bad++;
      end
      prev = in_flat_o;
    end
    start_i = 1'b0;
    check("done", done_o, 1'b1);
    check("done_cyc", cyc, (nv == 0) ? 0 : NWORDS * (nv + 1));
    check("n_pub", k, nv);
    check("vec_cnt", vec_cnt_o, nv);
    check("sig", sig_o, m_sig);
    check("busy_end", busy_o, 1'b0);
    check("stable", bad, 0);
    if (nv > 0) check("hold", in_flat_o, exp_q[nv-1]);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_in"}, in_flat_o, '0);
    check({tag, "_vv"}, vec_valid_o, 1'b0);
    check({tag, "_busy"}, busy_o, 1'b0);
    check({tag, "_done"}, done_o, 1'b0);
    check({tag, "_cnt"}, vec_cnt_o, '0);
    check({tag, "_sig"}, sig_o, '0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] lo;
    rst_n       = 1'b0;
    seed_load_i = 1'b0;
    seed_i      = '0;
    start_i     = 1'b0;
    num_vec_i   = '0;
    mode_i      = '0;
    resp_mode   = 1'b0;
    salt        = '0;
    m_rng       = SEED;
    repeat (3) @(posedge clk);
    #1;
    check_reset_state("rst");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Known answers from seed 0 and a constant-1 response.
    run(1'b1, 32'd0, 2'd0, 1);
    lo = in_flat_o[63:0];
    check("kat_lcg", lo, 64'hD3DC167E_00003039);
    run(1'b1, 32'd0, 2'd0, 2);
    check("kat_sig", sig_o, 32'h3);
    run(1'b1, 32'd0, 2'd1, 3);
    lo = in_flat_o[63:0];
    check("kat_hold", lo, 64'hD3DC167E_00003039);
    run(1'b0, 32'd0, 2'd0, 1);
    run(1'b0, 32'd0, 2'd2, 3);
    run(1'b0, 32'd0, 2'd0, 0);
    run(1'b0, 32'd0, 2'd3, 2);
    run(1'b0, 32'd0, 2'd2, IN_W + 2);

    resp_mode = 1'b1;
    for (int r = 0; r < 10; r++) begin
      for (int b = 0; b < OUT_W; b++) salt[b] = 1'($urandom);
      run(1'($urandom_range(0, 1)), $urandom, 2'($urandom), int'($urandom_range(0, 6)));
    end

    // Mid-run reset, then a fresh run must replay the SEED sequence.
    seed_load_i = 1'b0;
    mode_i      = 2'd0;
    num_vec_i   = CNT_W'(5);
    start_i     = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_reset_state("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    m_rng = SEED;
    @(posedge clk); #1;
    run(1'b0, 32'd0, 2'd0, 5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
